// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order completing instructions.
// Latency: a writeback is visible to commit/flush on the following cycle; commit is combinational from state.
// Backpressure: disp_ready drops when full or flushing; a same-cycle commit does not open a slot.
// Optional feature: define ROB_LOOKUP_EN to add the youngest-producer operand lookup port (lk_*).
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [4:0]      disp_rd,
  input  logic            disp_wen,
  input  logic [XLEN-1:0] disp_pc,
  output logic [TAGW-1:0] disp_tag,
  input  logic            wb_valid,
  input  logic [TAGW-1:0] wb_tag,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_exc,
  output logic            cmt_valid,
  output logic [4:0]      cmt_rd,
  output logic            cmt_wen,
  output logic [XLEN-1:0] cmt_data,
  output logic [XLEN-1:0] cmt_pc,
  output logic            flush_valid,
  output logic [XLEN-1:0] flush_pc,
  output logic [TAGW:0]   count
`ifdef ROB_LOOKUP_EN
  ,
  input  logic [4:0]      lk_rs,
  output logic            lk_hit,
  output logic            lk_done,
  output logic [TAGW-1:0] lk_tag,
  output logic [XLEN-1:0] lk_data
`endif
);

  // Per-entry state, indexed by tag
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_exc;
  logic [DEPTH-1:0] r_wen;
  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];

  logic [TAGW-1:0]  r_head;
  logic [TAGW-1:0]  r_tail;
  logic [TAGW:0]    r_count;

  logic w_head_fire;
  logic w_commit;
  logic w_flush;
  logic w_disp;
  logic w_full;

  assign w_head_fire = r_vld[r_head] & r_done[r_head];
  assign w_commit    = w_head_fire & ~r_exc[r_head];
  assign w_flush     = w_head_fire &  r_exc[r_head];
  assign w_full      = (r_count == (TAGW+1)'(DEPTH));
  // Reset gates ready directly so it reads 0 while reset is held
  assign disp_ready  = ~reset & ~w_full & ~w_flush;
  assign w_disp      = disp_valid & disp_ready;

  assign disp_tag    = r_tail;
  assign count       = r_count;
  assign cmt_valid   = w_commit;
  assign cmt_rd      = w_commit ? r_rd[r_head]   : '0;
  assign cmt_wen     = w_commit ? r_wen[r_head]  : 1'b0;
  assign cmt_data    = w_commit ? r_data[r_head] : '0;
  assign cmt_pc      = w_commit ? r_pc[r_head]   : '0;
  assign flush_valid = w_flush;
  assign flush_pc    = w_flush ? r_pc[r_head] : '0;

  // Dispatch at tail, writeback by tag, retire/flush at head, occupancy tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_wen   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (w_flush) begin
      // Faulting head squashes everything younger; writebacks this cycle are moot
      r_vld   <= '0;
      r_done  <= '0;
      r_exc   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (wb_valid && r_vld[wb_tag]) begin
        r_done[wb_tag] <= 1'b1;
        r_exc[wb_tag]  <= wb_exc;
        r_data[wb_tag] <= wb_data;
      end
      // Tail slot is never valid when dispatch is allowed, so no clash with writeback
      if (w_disp) begin
        r_vld[r_tail]  <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_exc[r_tail]  <= 1'b0;
        r_wen[r_tail]  <= disp_wen;
        r_rd[r_tail]   <= disp_rd;
        r_pc[r_tail]   <= disp_pc;
        r_tail         <= r_tail + TAGW'(1);
      end
      if (w_commit) begin
        r_vld[r_head]  <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + TAGW'(1);
      end
      case ({w_disp, w_commit})
        2'b10:   r_count <= r_count + (TAGW+1)'(1);
        2'b01:   r_count <= r_count - (TAGW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ROB_LOOKUP_EN
  logic [TAGW-1:0] w_lk_idx;

  // Walk oldest to youngest so the last match (youngest producer) wins
  always_comb begin
    lk_hit   = 1'b0;
    lk_done  = 1'b0;
    lk_tag   = '0;
    lk_data  = '0;
    w_lk_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_lk_idx = r_head + TAGW'(i);
      if (r_vld[w_lk_idx] && r_wen[w_lk_idx] && (r_rd[w_lk_idx] == lk_rs) && (lk_rs != 5'd0)) begin
        lk_hit  = 1'b1;
        lk_done = r_done[w_lk_idx];
        lk_tag  = w_lk_idx;
        lk_data = r_data[w_lk_idx];
      end
    end
  end
`endif

endmodule
